// File: rtl/osc_pkg.sv
// Shared encodings and LFSR constants for the wave oscillator.
// Latency: n/a (constants only).
// Backpressure: n/a (constants only).
package osc_pkg;

  localparam logic [1:0] MODE_PULSE = 2'b00;
  localparam logic [1:0] MODE_SAW   = 2'b01;
  localparam logic [1:0] MODE_TRI   = 2'b10;
  localparam logic [1:0] MODE_NOISE = 2'b11;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Right-shifting Fibonacci register: bits 0,2,3,5 correspond to taps 16,14,13,11.
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

endpackage

// File: rtl/osc_lfsr.sv
// 16-bit Fibonacci LFSR noise source, advances once per step.
// Latency: state_next is combinational; state updates 1 clock after step.
// Backpressure: none; step is a pure enable.
module osc_lfsr
  import osc_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        step,
  output logic [15:0] state,
  output logic [15:0] state_next
);

  // Feedback is the parity of the tapped bits shifted in at the top.
  assign state_next = {^(state & LFSR_TAPS), state[15:1]};

  // Register advances only on a phase step; reset reseeds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= LFSR_SEED;
    end else if (step) begin
      state <= state_next;
    end
  end

endmodule

// File: rtl/wave_osc.sv
// Counter-based audio oscillator: pulse / saw / triangle (noise with WAVE_OSC_NOISE_EN).
// Latency: data is registered, 1 clock after the phase/shadow state it reflects.
// Backpressure: none; en=0 freezes prescaler, phase and data, sync restarts the phase.
module wave_osc
  import osc_pkg::*;
#(
  parameter int CNT_W  = 12,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              sync,
  input  logic [CNT_W-1:0]  count_max,
  input  logic [DATA_W-1:0] duty,
  input  logic [1:0]        mode,
  output logic [DATA_W-1:0] data,
  output logic              period_tick
);

  logic [CNT_W-1:0]  presc, presc_next;
  logic [DATA_W-1:0] phase, phase_next;
  logic [1:0]        mode_s, mode_next;
  logic [DATA_W-1:0] duty_s, duty_next;
  logic [DATA_W-1:0] tri_u;
  logic [DATA_W-1:0] sample_next;
  logic              started;
  logic              step;
  logic              wrap;
  logic              shadow_load;

`ifdef WAVE_OSC_NOISE_EN
  logic [15:0] lfsr_q, lfsr_adv, noise_next;

  osc_lfsr u_lfsr (
    .clk        (clk),
    .rst_n      (rst_n),
    .step       (step),
    .state      (lfsr_q),
    .state_next (lfsr_adv)
  );

  assign noise_next = step ? lfsr_adv : lfsr_q;
`endif

  // Next-state for prescaler, phase and the glitch-free mode/duty shadows.
  always_comb begin
    step       = 1'b0;
    presc_next = presc;
    phase_next = phase;
    if (sync) begin
      presc_next = '0;
      phase_next = '0;
    end else if (en) begin
      // >= so a lowered count_max wraps promptly instead of running to overflow.
      if (presc >= count_max) begin
        presc_next = '0;
        step       = 1'b1;
        phase_next = phase + 1'b1;
      end else begin
        presc_next = presc + 1'b1;
      end
    end
    wrap        = step && (phase == '1);
    shadow_load = wrap || sync || !en || !started;
    mode_next   = shadow_load ? mode : mode_s;
    duty_next   = shadow_load ? duty : duty_s;
  end

  // Waveform function evaluated on the values being written this cycle.
  always_comb begin
    sample_next = '0;
    tri_u       = {phase_next[DATA_W-2:0], 1'b0};
    case (mode_next)
      MODE_PULSE: sample_next = (phase_next < duty_next) ? '1 : '0;
      MODE_SAW:   sample_next = phase_next;
      MODE_TRI:   sample_next = phase_next[DATA_W-1] ? ~tri_u : tri_u;
      default: begin
`ifdef WAVE_OSC_NOISE_EN
        sample_next = noise_next[DATA_W-1:0];
`else
        sample_next = '0;
`endif
      end
    endcase
  end

  // State and output registers; data holds while disabled unless sync forces a restart.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc       <= '0;
      phase       <= '0;
      mode_s      <= MODE_PULSE;
      duty_s      <= '0;
      started     <= 1'b0;
      data        <= '0;
      period_tick <= 1'b0;
    end else begin
      presc       <= presc_next;
      phase       <= phase_next;
      mode_s      <= mode_next;
      duty_s      <= duty_next;
      started     <= started | en;
      if (sync || en) begin
        data <= sample_next;
      end
      period_tick <= wrap;
    end
  end

endmodule

// File: tb/tb_wave_osc.sv
// Self-checking bench for wave_osc against a behavioural reference model.
// Latency: model predicts the registered sample seen one clock after each edge.
// Backpressure: n/a.
module tb_wave_osc;

  localparam int CW = 12;
  localparam int DW = 8;
  localparam int NP = 1 << DW;

  logic          clk;
  logic          rst_n;
  logic          en;
  logic          sync;
  logic [CW-1:0] count_max;
  logic [DW-1:0] duty;
  logic [1:0]    mode;
  logic [DW-1:0] data;
  logic          period_tick;

  int vectors;
  int miscompares;

  // Reference model state (plain integers, rules as written for the oscillator)
  int          m_cnt, m_phase, m_mode, m_duty, m_data;
  bit          m_tick, m_started;
  logic [15:0] m_lfsr;

  wave_osc #(.CNT_W(CW), .DATA_W(DW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .sync        (sync),
    .count_max   (count_max),
    .duty        (duty),
    .mode        (mode),
    .data        (data),
    .period_tick (period_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] lfsr_adv(input logic [15:0] l);
    logic b;
    b = l[0] ^ l[2] ^ l[3] ^ l[5];
    return {b, l[15:1]};
  endfunction

  function automatic int ref_wave(input int ph, input int md, input int dt, input logic [15:0] lf);
    case (md)
      0: return (ph < dt) ? NP - 1 : 0;
      1: return ph;
      2: return (ph < NP / 2) ? 2 * ph : (NP - 1) - 2 * (ph - NP / 2);
      default: begin
`ifdef WAVE_OSC_NOISE_EN
        return int'(lf) % NP;
`else
        return 0;
`endif
      end
    endcase
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_phase = 0; m_mode = 0; m_duty = 0; m_data = 0;
    m_tick = 0; m_started = 0; m_lfsr = 16'hACE1;
  endtask

  // Advance the model by one clock using the inputs present at the edge.
  task automatic model_clock();
    bit stepped, wrapped;
    if (sync) begin
      m_cnt = 0; m_phase = 0; m_mode = mode; m_duty = duty; m_tick = 0;
      if (en) m_started = 1;
      m_data = ref_wave(m_phase, m_mode, m_duty, m_lfsr);
    end else if (!en) begin
      m_mode = mode; m_duty = duty; m_tick = 0;
    end else begin
      stepped = (m_cnt >= int'(count_max));
      wrapped = stepped && (m_phase == NP - 1);
      m_cnt = stepped ? 0 : m_cnt + 1;
      if (stepped) begin
        m_phase = (m_phase + 1) % NP;
        m_lfsr  = lfsr_adv(m_lfsr);
      end
      if (wrapped || !m_started) begin
        m_mode = mode; m_duty = duty;
      end
      m_started = 1;
      m_data = ref_wave(m_phase, m_mode, m_duty, m_lfsr);
      m_tick = wrapped;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_clock();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; sync = 1'b0; count_max = '0; duty = '0; mode = 2'b00;
    model_reset();
    #12;
    vectors++;
    if (data !== '0 || period_tick !== 1'b0) begin
      miscompares++;
      $display("FAIL reset: data=%0h tick=%0b expected 0/0", data, period_tick);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_saw();
    en = 1'b1; count_max = '0; mode = 2'b01;
    for (int i = 1; i <= 260; i++) begin
      cyc();
      vectors++;
      if (data !== DW'(i % NP) || period_tick !== (i % NP == 0)) begin
        miscompares++;
        $display("FAIL saw i=%0d: data=%0h tick=%0b expected %0h/%0b", i, data, period_tick, i % NP, (i % NP == 0));
      end
    end
  endtask

  task automatic test_pulse();
    int highs0, highs1, budget;
    mode = 2'b00; duty = 8'd128;
    budget = 0;
    while (period_tick !== 1'b1 && budget < 600) begin
      cyc(); budget++;
    end
    vectors++;
    if (period_tick !== 1'b1) begin
      miscompares++;
      $display("FAIL pulse_wait: no period_tick within %0d cycles", budget);
    end
    highs0 = (data == 8'hFF) ? 1 : 0;
    highs1 = 0;
    for (int i = 1; i < 512; i++) begin
      if (i == 64) duty = 8'd64;
      cyc();
      vectors++;
      if (data !== m_data[DW-1:0] || period_tick !== m_tick) begin
        miscompares++;
        $display("FAIL pulse i=%0d: data=%0h tick=%0b expected %0h/%0b", i, data, period_tick, m_data[DW-1:0], m_tick);
      end
      if (i < 256) highs0 += (data == 8'hFF) ? 1 : 0;
      else         highs1 += (data == 8'hFF) ? 1 : 0;
      if (i == 256) begin
        vectors++;
        if (period_tick !== 1'b1) begin
          miscompares++;
          $display("FAIL pulse_period: tick=%0b expected 1 at 256", period_tick);
        end
      end
    end
    vectors++;
    if (highs0 != 128 || highs1 != 64) begin
      miscompares++;
      $display("FAIL pulse_duty: highs=%0d,%0d expected 128,64", highs0, highs1);
    end
  endtask

  task automatic test_triangle();
    int budget, len;
    mode = 2'b10; count_max = 12'd2;
    budget = 0;
    while (period_tick !== 1'b1 && budget < 2000) begin
      cyc(); budget++;
    end
    vectors++;
    if (period_tick !== 1'b1) begin
      miscompares++;
      $display("FAIL tri_wait: no period_tick within %0d cycles", budget);
    end
    len = 0;
    do begin
      cyc(); len++;
      vectors++;
      if (data !== m_data[DW-1:0] || period_tick !== m_tick) begin
        miscompares++;
        $display("FAIL tri len=%0d: data=%0h tick=%0b expected %0h/%0b", len, data, period_tick, m_data[DW-1:0], m_tick);
      end
      if (len == 3 || len == 384) begin
        vectors++;
        if (data !== ((len == 3) ? 8'd2 : 8'd255)) begin
          miscompares++;
          $display("FAIL tri_value at %0d: data=%0h", len, data);
        end
      end
    end while (period_tick !== 1'b1 && len < 1000);
    vectors++;
    if (len != 768) begin
      miscompares++;
      $display("FAIL tri_period: got %0d clocks expected 768", len);
    end
  endtask

  task automatic test_count_max_lower();
    logic [DW-1:0] d0;
    int budget;
    mode = 2'b01; count_max = 12'd100; sync = 1'b1;
    cyc();
    sync = 1'b0;
    budget = 0;
    while (m_cnt != 50 && budget < 200) begin
      cyc(); budget++;
    end
    count_max = 12'd5;
    d0 = data;
    for (int i = 1; i <= 13; i++) begin
      cyc();
      vectors++;
      if (data !== m_data[DW-1:0] || data !== DW'(d0 + ((i + 5) / 6))) begin
        miscompares++;
        $display("FAIL cmax_lower i=%0d: data=%0h expected %0h", i, data, DW'(d0 + ((i + 5) / 6)));
      end
    end
  endtask

  task automatic test_en_freeze();
    logic [DW-1:0] held;
    count_max = '0;
    held = data;
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      mode = 2'($urandom_range(0, 2)); duty = 8'($urandom);
      cyc();
      vectors++;
      if (data !== held || period_tick !== 1'b0) begin
        miscompares++;
        $display("FAIL en_freeze i=%0d: data=%0h tick=%0b expected %0h/0", i, data, period_tick, held);
      end
    end
    en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cyc();
      vectors++;
      if (data !== m_data[DW-1:0] || period_tick !== m_tick) begin
        miscompares++;
        $display("FAIL en_resume i=%0d: data=%0h tick=%0b expected %0h/%0b", i, data, period_tick, m_data[DW-1:0], m_tick);
      end
    end
  endtask

  task automatic test_sync();
    int budget;
    mode = 2'b01; count_max = '0; sync = 1'b1;
    cyc();
    sync = 1'b0;
    budget = 0;
    while (data !== 8'h80 && budget < 300) begin
      cyc(); budget++;
    end
    sync = 1'b1;
    cyc();
    sync = 1'b0;
    vectors++;
    if (data !== 8'h00 || period_tick !== 1'b0) begin
      miscompares++;
      $display("FAIL sync: data=%0h tick=%0b expected 0/0", data, period_tick);
    end
    cyc();
    vectors++;
    if (data !== 8'h01) begin
      miscompares++;
      $display("FAIL sync_next: data=%0h expected 01", data);
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 37; i++) cyc();
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (data !== '0 || period_tick !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset: data=%0h tick=%0b expected 0/0", data, period_tick);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    vectors++;
    if (data !== 8'h01 || data !== m_data[DW-1:0]) begin
      miscompares++;
      $display("FAIL post_reset: data=%0h expected 01", data);
    end
  endtask

  task automatic test_noise();
    mode = 2'b11; count_max = '0; sync = 1'b1;
    cyc();
    sync = 1'b0;
    for (int i = 0; i < 40; i++) begin
      cyc();
      vectors++;
      if (data !== m_data[DW-1:0]) begin
        miscompares++;
        $display("FAIL noise i=%0d: data=%0h expected %0h", i, data, m_data[DW-1:0]);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      en   = ($urandom_range(0, 9) != 0);
      sync = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 49) == 0) count_max = CW'($urandom_range(0, 3));
      if ($urandom_range(0, 19) == 0) mode = 2'($urandom);
      if ($urandom_range(0, 19) == 0) duty = 8'($urandom);
      cyc();
      vectors++;
      if (data !== m_data[DW-1:0] || period_tick !== m_tick) begin
        miscompares++;
        $display("FAIL random i=%0d: data=%0h tick=%0b expected %0h/%0b", i, data, period_tick, m_data[DW-1:0], m_tick);
      end
    end
    en = 1'b1; sync = 1'b0;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_saw();
    test_pulse();
    test_triangle();
    test_count_max_lower();
    test_en_freeze();
    test_sync();
    test_async_reset();
    test_noise();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/wave_osc.md
Name: wave_osc

Overview:
- Parametrised successor to the single-bit pulse generator: a counter-based audio oscillator with selectable pulse (variable duty), sawtooth and triangle waveforms.
- Registered DATA_W-bit sample output.
- Sits between the register/control block (supplies pitch, duty, mode) and the mixer/PWM output stage.
- Glitch-free parameter updates: mode and duty change only at waveform period boundaries.

Parameters:
- CNT_W, 12, width of prescaler counter and count_max.
- DATA_W, 8, sample width and phase width (2..16).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  run enable; 0 freezes counters and output
- sync  in  1  synchronous phase restart
- count_max  in  CNT_W  prescaler terminal value; phase step every count_max+1 enabled clocks
- duty  in  DATA_W  pulse threshold
- mode  in  2  00 pulse, 01 saw, 10 triangle, 11 noise/silence
- data  out  DATA_W  registered sample
- period_tick  out  1  one-cycle strobe at phase wrap

Interface note: one clock; reset is asynchronous and active-low.

Behaviour:
- Reset (rst_n=0, async): prescaler=0, phase=0, shadow mode=00, shadow duty=0, data=0, period_tick=0.
- Prescaler:
  - When en=1: if prescaler >= count_max, prescaler<=0 and step=1; else prescaler+1, step=0.
  - The >= compare guarantees prompt wrap when count_max is lowered below the current count.
  - count_max takes effect immediately; it is not shadowed.
- Phase: on step, phase<=phase+1, modulo 2^DATA_W. wrap = step && phase==all-ones.
- Shadow registers (mode_s, duty_s) load from the inputs when any of these holds:
  - wrap
  - sync
  - en=0
  - the first enabled cycle after reset
- Waveform function f(phase, mode_s, duty_s):
  - pulse: all-ones if phase < duty_s, else 0. duty 0 gives constant 0; duty 255 gives 255 high / 1 low per period.
  - saw: phase.
  - triangle: let u={phase[DATA_W-2:0],0}; output u if phase MSB=0, else ~u. Sequence for DATA_W=8: 0,2,…,254,255,253,…,1.
  - 11 without NOISE_EN: 0.
- Output register, updated every enabled cycle:
  - data <= f(phase_next, mode_next, duty_next), where *_next are the values being written this cycle.
  - So data reflects the new phase in the cycle after a step; latency is 1 clock from state change.
- period_tick <= wrap. It is high in the same cycle data first shows phase 0.
- en=0: prescaler, phase, data hold; period_tick=0; shadows track inputs.
- sync=1 (sync has priority over en and over step):
  - prescaler<=0, phase<=0, shadows load.
  - Next cycle, data=f(0, mode, duty).
  - period_tick=0 on sync.
- Simultaneous wrap and input change: new mode/duty apply starting with the phase-0 sample.
- Reset asserted mid-period: immediate return to reset values; no pending state survives.
- Frequency: f_out = f_clk / ((count_max+1)·2^DATA_W).

Optional Feature:
- Macro: WAVE_OSC_NOISE_EN.
- When defined, mode 11 selects noise:
  - 16-bit Fibonacci LFSR, taps 16,14,13,11, seed 0xACE1 at reset.
  - Advances on each step.
  - data = lfsr[DATA_W-1:0], registered like the other waveforms.
  - sync does not reseed.
- When undefined: no LFSR logic; mode 11 outputs 0; period_tick still runs.

Decomposition:
- Package osc_pkg:
  - mode encodings MODE_PULSE=2'b00, MODE_SAW=2'b01, MODE_TRI=2'b10, MODE_NOISE=2'b11.
  - LFSR seed constant 16'hACE1 and tap mask.
- Sub-module osc_lfsr (16-bit, step enable, async active-low reset), instantiated only under WAVE_OSC_NOISE_EN.
- Prescaler, phase and waveform mux stay in wave_osc.

Test Plan:
- Reset then en=1, count_max=0, mode=01 -> data 0 then 1,2,…,255,0 on consecutive clocks; period_tick high exactly when data returns to 0, every 256 clocks.
- mode=00, duty=128, count_max=0 -> 128 clocks 0xFF, 128 clocks 0x00, repeating. Change duty to 64 mid-period -> current period unchanged; the next period is 64 high / 192 low.
- mode=10, count_max=2 -> each triangle value held 3 clocks; sequence 0,2,…,254,255,253,…,1; period 768 clocks.
- count_max lowered 100->5 while prescaler=50 -> step on the next cycle, then every 6 clocks. en=0 for 10 clocks -> data and phase frozen, period_tick low.
- sync pulse mid-saw at phase 0x80 -> data=0x00 the next cycle. rst_n asserted mid-operation -> data=0 and period_tick=0 immediately, asynchronously.
- With WAVE_OSC_NOISE_EN, mode=11, count_max=0 -> first data values match the LFSR sequence from 0xACE1. Without the macro -> data constant 0.
